// File: rtl/game_manager_pkg.sv
// Shared definitions for the pinball game manager: phase encoding and
// the default number of lives a fresh game starts with.
package game_manager_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2,
        WIN       = 2'd3
    } game_state_t;

    localparam int LIFE_INIT = 3;

endpackage

// File: rtl/game_manager_rise_detect.sv
// Per-bit rising-edge detector: pulses for one cycle when a bit goes from 0 to 1
// relative to its value on the previous clock.
module rise_detect #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic [N-1:0] in_i,
    output logic [N-1:0] pulse_o
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_q <= '0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign pulse_o = in_i & ~prev_q;

endmodule

// File: rtl/game_manager.sv
// Pinball game sequencer: walks READY/PLAY/GAME_OVER/WIN and keeps per-level
// score, level, lives and a saturating total score from edge-qualified events.
module game_manager
    import game_manager_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int TOTAL_W     = 8,
    parameter int LEVEL_W     = 4,
    parameter int LIFE_W      = 4,
    parameter int LIFE_INIT   = game_manager_pkg::LIFE_INIT,
    parameter int LIFE_MAX    = 9,
    parameter int NUM_LEVELS  = 4,
    parameter int TARGET_BASE = 2,
    parameter int TARGET_STEP = 1,
    parameter int BONUS_LIFE  = 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               key5IsPressed,
    input  logic               collisionSmileyBorderBottom,
    input  logic               collisionSmileyObstacle,
    input  logic               collisionSmileyObstacleGood,
    input  logic               collisionSmileyObstacleBad,
    output logic               pause,
    output logic               reset_level,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [LIFE_W-1:0]  life,
    output logic [TOTAL_W-1:0] total_score,
    output logic               game_over,
    output logic               game_won
);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIFE_W-1:0]  life_q, life_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic [3:0]         rawEvents;
    logic [3:0]         pulses;
    logic               startEv, bottomEv, goodEv, badEv;
    logic [SCORE_W-1:0] target;
    logic               lastLevel;

    // Good/bad are only meaningful while the obstacle collision is asserted,
    // so the qualified terms are edge-detected rather than the raw inputs.
    assign rawEvents = {key5IsPressed,
                        collisionSmileyBorderBottom,
                        collisionSmileyObstacle & collisionSmileyObstacleGood,
                        collisionSmileyObstacle & collisionSmileyObstacleBad};

    rise_detect #(.N(4)) u_rise (
        .clk     (clk),
        .resetN  (resetN),
        .in_i    (rawEvents),
        .pulse_o (pulses)
    );

    assign {startEv, bottomEv, goodEv, badEv} = pulses;

    assign target    = SCORE_W'(TARGET_BASE + int'(level_q) * TARGET_STEP);
    assign lastLevel = (level_q == LEVEL_W'(NUM_LEVELS - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= READY;
            score_q <= '0;
            level_q <= '0;
            life_q  <= LIFE_W'(LIFE_INIT);
            total_q <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            level_q <= level_d;
            life_q  <= life_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        level_d = level_q;
        life_d  = life_q;
        total_d = total_q;
        case (state_q)
            READY: begin
                score_d = '0;
                if (startEv) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Only the highest-priority event of the cycle is acted on.
                if (bottomEv) begin
                    life_d = life_q - LIFE_W'(1);
                    if (life_q == LIFE_W'(1)) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d = READY;
                        score_d = '0;
                    end
                end else if (goodEv) begin
                    if (total_q != '1) begin
                        total_d = total_q + TOTAL_W'(1);
                    end
                    if (score_q == target - SCORE_W'(1)) begin
                        if (lastLevel) begin
                            state_d = WIN;
                        end else begin
                            state_d = READY;
                            level_d = level_q + LEVEL_W'(1);
                            score_d = '0;
                            if (BONUS_LIFE == 1 && life_q < LIFE_W'(LIFE_MAX)) begin
                                life_d = life_q + LIFE_W'(1);
                            end
                        end
                    end else begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (badEv) begin
                    if (score_q != '0) begin
                        score_d = score_q - SCORE_W'(1);
                    end
                end
            end
            GAME_OVER, WIN: begin
                // Restart skips READY so the new game launches immediately.
                if (startEv) begin
                    state_d = PLAY;
                    score_d = '0;
                    level_d = '0;
                    life_d  = LIFE_W'(LIFE_INIT);
                    total_d = '0;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign pause       = (state_q != PLAY);
    assign reset_level = (state_q != PLAY);
    assign game_over   = (state_q == GAME_OVER);
    assign game_won    = (state_q == WIN);
    assign score       = score_q;
    assign level       = level_q;
    assign life        = life_q;
    assign total_score = total_q;

endmodule
